// File: rtl/logo_fm_pkg.sv
// Shared definitions for the logo/menu memory bridge: memory geometry,
// default FM-PAC unlock constants, the access FSM state type and a helper
// that recognises the two unlock byte offsets.
package logo_fm_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] DEF_UNLOCK_ADDR = 14'h1FFE;
  localparam logic [DATA_W-1:0] DEF_UNLOCK_KEY0 = 8'h4D;
  localparam logic [DATA_W-1:0] DEF_UNLOCK_KEY1 = 8'h69;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_CAP,
    WR,
    HOLD
  } state_t;

  // True when offset addresses either of the two unlock bytes.
  function automatic logic is_unlock_byte(input logic [ADDR_W-1:0] offset,
                                          input logic [ADDR_W-1:0] base);
    return (offset == base) || (offset == base + ADDR_W'(1));
  endfunction

endpackage

// File: rtl/logo_fm_bridge_if.sv
// Memory-side bus of the bridge: a 14-bit address / 8-bit data synchronous
// memory with a one-clock registered read port. The bridge is the master,
// the memory instance is the slave.
interface logo_fm_bridge_if;
  import logo_fm_pkg::*;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  modport master (
    output mem_address,
    output mem_data,
    output mem_wren,
    input  mem_q
  );

  modport slave (
    input  mem_address,
    input  mem_data,
    input  mem_wren,
    output mem_q
  );

endinterface

// File: rtl/strobe_sync.sv
// Multi-stage synchroniser for an active-low CPU strobe, with a one-cycle
// falling-edge pulse on the synchronised output. Flops preset to 1 so the
// strobe reads inactive out of reset and no spurious edge is seen.
module strobe_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic strobe_n,
  output logic sync_n,
  output logic fall
);

  logic [STAGES-1:0] chain_q, chain_d;
  logic              prev_q, prev_d;

  // Shift the raw strobe through the chain and remember the last synced value.
  always_comb begin
    chain_d = {chain_q[STAGES-2:0], strobe_n};
    prev_d  = chain_q[STAGES-1];
  end

  // Synchroniser and edge-detect registers, preset to the inactive level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chain_q <= '1;
      prev_q  <= 1'b1;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
    end
  end

  assign sync_n = chain_q[STAGES-1];
  assign fall   = prev_q & ~chain_q[STAGES-1];

endmodule

// File: rtl/logo_fm_bridge.sv
// Bus-side initiator for the 16K logo/menu memory. Turns slow MSX slot
// cycles into single-clock memory accesses, captures read data at the
// memory's one-clock latency and holds it for the CPU, and only lets writes
// through after the FM-PAC-style two-byte unlock sequence.
// Optional feature: define LOGO_FM_WAIT_EN to drive wait_n low while an
// access is in flight; otherwise wait_n is tied high.
module logo_fm_bridge
  import logo_fm_pkg::*;
#(
  parameter int                SYNC_STAGES = 2,
  parameter logic [1:0]        BASE_PAGE   = 2'b01,
  parameter logic [ADDR_W-1:0] UNLOCK_ADDR = DEF_UNLOCK_ADDR,
  parameter logic [DATA_W-1:0] UNLOCK_KEY0 = DEF_UNLOCK_KEY0,
  parameter logic [DATA_W-1:0] UNLOCK_KEY1 = DEF_UNLOCK_KEY1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              slot_sel,
  input  logic [15:0]       cpu_addr,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              dout_valid,
  output logic              wait_n,
  output logic              unlocked,
  logo_fm_bridge_if.master  mem
);

  // Synchronised strobes with falling-edge detect.
  logic rd_sync_n, rd_fall;
  logic wr_sync_n, wr_fall;

  strobe_sync #(.STAGES(SYNC_STAGES)) u_rd_sync (
    .clock    (clock),
    .reset    (reset),
    .strobe_n (rd_n),
    .sync_n   (rd_sync_n),
    .fall     (rd_fall)
  );

  strobe_sync #(.STAGES(SYNC_STAGES)) u_wr_sync (
    .clock    (clock),
    .reset    (reset),
    .strobe_n (wr_n),
    .sync_n   (wr_sync_n),
    .fall     (wr_fall)
  );

  // slot_sel only needs the level, so a plain synchroniser cleared on reset.
  logic [SYNC_STAGES-1:0] sel_sync_q, sel_sync_d;
  logic                   sel_sync;

  // Shift slot_sel through its synchroniser chain.
  always_comb begin
    sel_sync_d = {sel_sync_q[SYNC_STAGES-2:0], slot_sel};
  end

  // slot_sel synchroniser registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sel_sync_q <= '0;
    else       sel_sync_q <= sel_sync_d;
  end

  assign sel_sync = sel_sync_q[SYNC_STAGES-1];

  // Decode: the CPU holds address and data stable while its strobe is low.
  logic [ADDR_W-1:0] offset;
  logic              hit, rd_start, wr_start;

  assign offset   = cpu_addr[ADDR_W-1:0];
  assign hit      = sel_sync && (cpu_addr[15:14] == BASE_PAGE);
  assign rd_start = rd_fall && hit;
  // A read that starts in the same cycle wins; that write edge is dropped.
  assign wr_start = wr_fall && hit && !rd_start;

  // FSM and output registers.
  state_t            state_q, state_d;
  logic              rd_op_q, rd_op_d;
  logic [DATA_W-1:0] cpu_dout_q, cpu_dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              mem_wren_q, mem_wren_d;
  logic              armed_q, armed_d;
  logic              unlocked_q, unlocked_d;
  logic              strobe_released;

  assign strobe_released = rd_op_q ? rd_sync_n : wr_sync_n;

  // Next-state, datapath and unlock-tracker logic for one access at a time.
  always_comb begin
    state_d       = state_q;
    rd_op_d       = rd_op_q;
    cpu_dout_d    = cpu_dout_q;
    dout_valid_d  = dout_valid_q;
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    mem_wren_d    = 1'b0;
    armed_d       = armed_q;
    unlocked_d    = unlocked_q;

    case (state_q)
      IDLE: begin
        if (rd_start) begin
          mem_address_d = offset;
          rd_op_d       = 1'b1;
          state_d       = RD_ADDR;
        end else if (wr_start) begin
          rd_op_d = 1'b0;
          state_d = WR;
        end
      end

      // Address is on the bus; memory registers it at the end of this cycle.
      RD_ADDR: state_d = RD_CAP;

      RD_CAP: begin
        cpu_dout_d   = mem.mem_q;
        dout_valid_d = 1'b1;
        state_d      = HOLD;
      end

      WR: begin
        mem_data_d    = cpu_din;
        mem_address_d = offset;
        mem_wren_d    = unlocked_q && !is_unlock_byte(offset, UNLOCK_ADDR);
        // Only a KEY0 write to the first byte leaves the tracker armed;
        // any other write, including the second byte, consumes or disarms it.
        armed_d = (offset == UNLOCK_ADDR) && (cpu_din == UNLOCK_KEY0);
        if (offset == UNLOCK_ADDR + ADDR_W'(1)) begin
          if (cpu_din != UNLOCK_KEY1) unlocked_d = 1'b0;
          else if (armed_q)           unlocked_d = 1'b1;
        end
        state_d = HOLD;
      end

      // Access is committed; wait for the CPU to end its cycle.
      HOLD: begin
        if (strobe_released) begin
          dout_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Register FSM state and all outputs; reset aborts any access at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      rd_op_q       <= 1'b0;
      cpu_dout_q    <= '0;
      dout_valid_q  <= 1'b0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      mem_wren_q    <= 1'b0;
      armed_q       <= 1'b0;
      unlocked_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_op_q       <= rd_op_d;
      cpu_dout_q    <= cpu_dout_d;
      dout_valid_q  <= dout_valid_d;
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
      mem_wren_q    <= mem_wren_d;
      armed_q       <= armed_d;
      unlocked_q    <= unlocked_d;
    end
  end

  assign cpu_dout        = cpu_dout_q;
  assign dout_valid      = dout_valid_q;
  assign unlocked        = unlocked_q;
  assign mem.mem_address = mem_address_q;
  assign mem.mem_data    = mem_data_q;
  assign mem.mem_wren    = mem_wren_q;

`ifdef LOGO_FM_WAIT_EN
  // Hold the CPU from the start edge until read data is valid or the write
  // cycle has been issued.
  assign wait_n = !((state_q == IDLE && (rd_start || wr_start)) ||
                    state_q == RD_ADDR || state_q == RD_CAP || state_q == WR);
`else
  // The bridge clock is fast enough that the CPU never needs to wait.
  assign wait_n = 1'b1;
`endif

endmodule

// File: doc/logo_fm_bridge.md
Name: logo_fm_bridge

Overview:
- Bus-side initiator for the 16K synchronous logo/menu memory (14-bit address, 8-bit data, `wren`, registered `q` valid one clock after the address).
- Converts slow MSX slot cycles (`rd_n`/`wr_n` strobes, slot select) into single-clock memory accesses.
- Captures read data at the correct latency and holds it for the CPU.
- Gates writes behind an FM-PAC-style unlock sequence.
- Sits between the slot decoder and the memory instance.

Parameters:
- `SYNC_STAGES`, 2, flip-flop stages synchronising `rd_n`/`wr_n`/`slot_sel` into the `clock` domain (min 2).
- `BASE_PAGE`, 2'b01, CPU page (A15:A14) mapped to the memory; default 0x4000-0x7FFF.
- `UNLOCK_ADDR`, 14'h1FFE, offset of the first unlock byte; the second byte is at `UNLOCK_ADDR`+1.
- `UNLOCK_KEY0`, 8'h4D, first unlock byte.
- `UNLOCK_KEY1`, 8'h69, second unlock byte.

Ports:
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `slot_sel` in 1: slot decoder select, active high.
- `cpu_addr` in 16: CPU address.
- `rd_n` in 1: CPU read strobe, active low.
- `wr_n` in 1: CPU write strobe, active low.
- `cpu_din` in 8: CPU write data.
- `cpu_dout` out 8: read data to CPU.
- `dout_valid` out 1: `cpu_dout` is valid for the current read.
- `wait_n` out 1: CPU wait request, active low.
- `mem_address` out 14: memory address.
- `mem_data` out 8: memory write data.
- `mem_wren` out 1: memory write enable, one-cycle pulse.
- `mem_q` in 8: memory read data, valid one clock after `mem_address`.
- `unlocked` out 1: write window open.

Behaviour:
- Reset (async): FSM to IDLE. `cpu_dout`=0, `dout_valid`=0, `wait_n`=1, `mem_address`=0, `mem_data`=0, `mem_wren`=0, `unlocked`=0. Synchroniser flops preset to 1 (strobes inactive); `slot_sel` sync cleared.
- Hit: synced `slot_sel`=1 AND `cpu_addr[15:14]`==`BASE_PAGE`. Address and data are sampled while the strobe is stable (CPU holds them); offset = `cpu_addr[13:0]`.
- Start events: falling edge of synced `rd_n` or `wr_n` with hit. If both fall in the same cycle, read wins and the write is ignored until the next falling edge.
- FSM states:
  - IDLE: `mem_address` <= offset on a read start -> RD_ADDR. On a write start -> WR.
  - RD_ADDR: one cycle, address presented -> RD_CAP.
  - RD_CAP: `cpu_dout` <= `mem_q`, `dout_valid` <= 1 -> HOLD.
  - WR: `mem_data` <= `cpu_din`, `mem_address` <= offset. `mem_wren` <= 1 for exactly one clock only if `unlocked`=1 and offset is outside the two unlock bytes. Update unlock tracker. -> HOLD.
  - HOLD: wait for synced strobe high. Then `dout_valid` <= 0 -> IDLE.
- Read latency: `dout_valid` rises 3 clocks after the synced `rd_n` falling edge.
- Unlock tracker, writes only:
  - Offset==`UNLOCK_ADDR` with data `UNLOCK_KEY0` arms the tracker.
  - Next hit write at `UNLOCK_ADDR`+1 with `UNLOCK_KEY1` sets `unlocked`=1.
  - Any other hit write while armed disarms it.
  - `UNLOCK_ADDR`+1 with any data other than `KEY1` clears `unlocked`.
  - Writes to the unlock bytes never assert `mem_wren`.
  - Reads do not affect the tracker.
- Strobe released mid-access (before RD_CAP): the FSM still completes to HOLD, then sees the strobe high and returns to IDLE; `dout_valid` pulses at most 1 cycle.
- `slot_sel` drop during HOLD: no effect, the access is already committed.
- Reset mid-access: immediate abort; no partial `mem_wren`.
- Address width: no wrap; offset is always 14 bits.

Optional Feature:
- `LOGO_FM_WAIT_EN` defined:
  - `wait_n` goes low combinationally from synced read-start until `dout_valid`=1.
  - For writes, low from write-start until the WR cycle completes.
  - High otherwise.
- Undefined: `wait_n` is constantly 1. The CPU relies on `clock` being at least 8x the CPU clock.

Decomposition:
- Shared package `logo_fm_pkg`:
  - FSM state enum (IDLE, RD_ADDR, RD_CAP, WR, HOLD).
  - Unlock constants 14'h1FFE, 8'h4D, 8'h69.
  - Memory geometry constants: ADDR_W=14, DATA_W=8.
- One sub-module: `strobe_sync`, a `SYNC_STAGES` synchroniser with falling-edge detect, instantiated for `rd_n` and `wr_n`. `slot_sel` uses the sync path only.

Test Plan:
- Read: memory model preloaded with 0x5A at offset 0x0123. CPU reads 0x4123 -> `mem_address`=0x0123, `cpu_dout`=0x5A, `dout_valid` high 3 clocks after synced `rd_n` fall, cleared after `rd_n` rises.
- Locked write: write 0xAA to 0x4010 from reset -> `mem_wren` never asserts, `unlocked`=0.
- Unlock: write 0x4D@0x5FFE, 0x69@0x5FFF, then 0xAA@0x4010 -> one `mem_wren` pulse with address 0x0010 and data 0xAA. A readback returns 0xAA.
- Broken sequence: 0x4D@0x5FFE, 0x11@0x4000, 0x69@0x5FFF -> `unlocked` stays 0. Then 0x00@0x5FFF after a valid unlock -> `unlocked`=0.
- Off-page and unselected: read at 0x8123, or with `slot_sel`=0 -> no FSM activity, `dout_valid`=0, `mem_wren`=0.
- Reset during RD_ADDR -> all outputs at reset values within the same cycle. A subsequent read works normally. With `LOGO_FM_WAIT_EN`, check `wait_n` low exactly from read-start to `dout_valid`.
